// File: rtl/mem_port_master_pkg.sv
// ----------------------------------------------------------------------------
// Module : mem_port_master_pkg
// Brief  : Memory-port op encodings, master FSM states and op decode helpers.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mem_port_master_pkg;

  localparam logic [2:0] MEM_OP_LW  = 3'd0;
  localparam logic [2:0] MEM_OP_LB  = 3'd1;
  localparam logic [2:0] MEM_OP_LBU = 3'd2;
  localparam logic [2:0] MEM_OP_SW  = 3'd3;
  localparam logic [2:0] MEM_OP_SB  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } mem_state_t;

  function automatic logic op_is_load(input logic [2:0] op);
    return (op == MEM_OP_LW) || (op == MEM_OP_LB) || (op == MEM_OP_LBU);
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == MEM_OP_SW) || (op == MEM_OP_SB);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_SB);
  endfunction

  function automatic logic op_is_known(input logic [2:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_master_byte_ext.sv
// ----------------------------------------------------------------------------
// Module : mem_byte_ext
// Brief  : Combinational load-data extension (LW pass, LB sign, LBU zero).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_byte_ext
  import mem_port_master_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      MEM_OP_LW:  result = data;
      MEM_OP_LB:  result = {{(WIDTH-8){data[7]}}, data[7:0]};
      MEM_OP_LBU: result = {{(WIDTH-8){1'b0}}, data[7:0]};
      default:    result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_master.sv
// ----------------------------------------------------------------------------
// Module : mem_port_master
// Brief  : Load/store initiator for the synchronous data memory port.
//          Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned LW/SW error).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_master
  import mem_port_master_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_data_in,
  input  logic [WIDTH-1:0]      mem_data_out,
  output logic                  mem_master_enable,
  output logic                  mem_write_enable,
  output logic                  mem_byte_enable
);

  mem_state_t            r_state, w_state_nxt;
  logic [2:0]            r_op, w_op_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0]      r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [WIDTH-1:0]      r_mem_data_in, w_mem_data_in_nxt;
  logic                  r_mem_en, w_mem_en_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic                  r_mem_be, w_mem_be_nxt;
  logic [WIDTH-1:0]      w_ext_data;
  logic                  w_misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = ((req_op == MEM_OP_LW) || (req_op == MEM_OP_SW)) &&
                        (req_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  mem_byte_ext #(.WIDTH(WIDTH)) u_byte_ext (
    .data   (mem_data_out),
    .op     (r_op),
    .result (w_ext_data)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_op_nxt          = r_op;
    w_req_ready_nxt   = 1'b0;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_data_in_nxt = r_mem_data_in;
    w_mem_en_nxt      = 1'b0;
    w_mem_we_nxt      = 1'b0;
    w_mem_be_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_req_ready_nxt = 1'b0;
          w_op_nxt        = req_op;
          if (w_misaligned) begin
            w_state_nxt     = ST_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_rsp_err_nxt   = 1'b1;
          end else if (!op_is_known(req_op)) begin
            // Unknown ops take the store timing but never strobe memory
            w_state_nxt = ST_ACCESS;
          end else begin
            w_state_nxt       = ST_ACCESS;
            w_mem_addr_nxt    = req_addr;
            w_mem_data_in_nxt = (req_op == MEM_OP_SB) ?
                                {{(WIDTH-8){1'b0}}, req_wdata[7:0]} : req_wdata;
            w_mem_en_nxt      = 1'b1;
            w_mem_we_nxt      = op_is_store(req_op);
            w_mem_be_nxt      = op_is_byte(req_op);
          end
        end
      end
      ST_ACCESS: begin
        if (op_is_load(r_op)) begin
          w_state_nxt = ST_READ_WAIT;
        end else begin
          w_state_nxt     = ST_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = !op_is_known(r_op);
        end
      end
      ST_READ_WAIT: begin
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = w_ext_data;
        w_rsp_err_nxt   = 1'b0;
      end
      ST_RESP: begin
        // Handshake returns to IDLE with req_ready already up for next cycle
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_be      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_op          <= w_op_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_data_in <= w_mem_data_in_nxt;
      r_mem_en      <= w_mem_en_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_be      <= w_mem_be_nxt;
    end
  end

  assign req_ready         = r_req_ready;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_rdata         = r_rsp_rdata;
  assign rsp_err           = r_rsp_err;
  assign mem_addr          = r_mem_addr;
  assign mem_data_in       = r_mem_data_in;
  assign mem_master_enable = r_mem_en;
  assign mem_write_enable  = r_mem_we;
  assign mem_byte_enable   = r_mem_be;

endmodule

`default_nettype wire
